// File: rtl/iter_div_ctrl_if.sv
// Operand/result handshake bundle for the iterative divider.
// The producer/consumer side uses master; the divider uses slave.
interface iter_div_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/iter_div_ctrl.sv
// Unsigned restoring divider: one quotient bit per cycle, WIDTH steps,
// IDLE/BUSY/DONE handshake control with results gated to zero outside DONE.
module iter_div_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  iter_div_ctrl_if.slave bus
);
  localparam int AW = WIDTH + 1;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [AW-1:0]    acc_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] d_r;
  logic [CW-1:0]    count_r;
  logic             dz_r;
  logic             rdy_en_r;

  logic             accept_s;
  logic             release_s;
  logic             last_step_s;
  logic [AW:0]      shift_s;
  logic             ge_s;
  logic [AW-1:0]    acc_nxt_s;

  logic             in_ready_s;
  logic             out_valid_s;
  logic [WIDTH-1:0] quotient_s;
  logic [WIDTH-1:0] remainder_s;
  logic             dz_out_s;

  assign accept_s    = bus.in_valid & in_ready_s;
  assign release_s   = out_valid_s & bus.out_ready;
  assign last_step_s = (count_r == CW'(WIDTH - 1));

  // Restoring step: shift the next dividend bit into the partial remainder, then trial-subtract.
  always_comb begin
    shift_s = {acc_r, q_r[WIDTH-1]};
    ge_s    = (shift_s >= {2'b00, d_r});
    if (ge_s) begin
      acc_nxt_s = AW'(shift_s - {2'b00, d_r});
    end else begin
      acc_nxt_s = shift_s[AW-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (accept_s) state_nxt_s = BUSY; else state_nxt_s = IDLE;
      BUSY:    if (last_step_s) state_nxt_s = DONE; else state_nxt_s = BUSY;
      DONE:    if (release_s) state_nxt_s = IDLE; else state_nxt_s = DONE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath registers; ready is held off until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r    <= '0;
      q_r      <= '0;
      d_r      <= '0;
      count_r  <= '0;
      dz_r     <= 1'b0;
      rdy_en_r <= 1'b0;
    end else begin
      rdy_en_r <= 1'b1;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            acc_r   <= '0;
            q_r     <= bus.dividend;
            d_r     <= bus.divisor;
            count_r <= '0;
            dz_r    <= (bus.divisor == '0);
          end
        end
        BUSY: begin
          acc_r   <= acc_nxt_s;
          q_r     <= {q_r[WIDTH-2:0], ge_s};
          count_r <= count_r + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode from state and datapath registers.
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    quotient_s  = '0;
    remainder_s = '0;
    dz_out_s    = 1'b0;
    case (state_r)
      IDLE: in_ready_s = rdy_en_r;
      DONE: begin
        out_valid_s = 1'b1;
        quotient_s  = q_r;
        remainder_s = acc_r[WIDTH-1:0];
        dz_out_s    = dz_r;
      end
      default: begin
      end
    endcase
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = out_valid_s;
  assign bus.quotient    = quotient_s;
  assign bus.remainder   = remainder_s;
  assign bus.div_by_zero = dz_out_s;
endmodule
